// File: rtl/datatape_pkg.sv
// Shared definitions for the tape-path line decoder.
//   START_MARKER : byte that opens every data-carrying line
//   CRC8_POLY    : CRC-8 generator polynomial (x^8 + x^2 + x + 1)
//   crc8_byte    : folds one byte into a running CRC-8 (MSB first, no reflection)
//   state_t      : line decoder FSM states
package datatape_pkg;

    localparam logic [7:0] START_MARKER = 8'hA5;
    localparam logic [7:0] CRC8_POLY    = 8'h07;

    typedef enum logic [2:0] {
        IDLE,
        SKIP,
        MARKER,
        PAYLOAD,
        CHECK,
        COMMIT,
        DROP
    } state_t;

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/commit_fifo.sv
// Byte FIFO with speculative writes. Bytes land at wr_spec but only become
// visible to the reader once commit copies wr_spec into wr_commit; rollback
// discards everything written since the last commit.
//   clk, rst        : clock, asynchronous active-low reset
//   wr_en, wr_data  : speculative write
//   commit          : publish all speculative bytes
//   rollback        : discard all speculative bytes
//   pop_ready       : consumer accepts dout (pop when dout_valid)
//   dout, dout_valid: first-word-fall-through head of committed data
//   free            : entries not occupied by committed or speculative data
//   level           : committed entries
module commit_fifo #(
    parameter  int DEPTH = 128,
    localparam int AW    = $clog2(DEPTH),
    localparam int PW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          commit,
    input  logic          rollback,
    input  logic          pop_ready,
    output logic [7:0]    dout,
    output logic          dout_valid,
    output logic [PW-1:0] free,
    output logic [PW-1:0] level
);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_spec;
    logic [PW-1:0] wr_commit;
    logic [PW-1:0] rd;

    // Pointers carry one extra bit so full and empty stay distinguishable.
    assign dout_valid = (wr_commit != rd);
    assign dout       = dout_valid ? mem[rd[AW-1:0]] : 8'h00;
    assign level      = wr_commit - rd;
    assign free       = PW'(DEPTH) - (wr_spec - rd);

    always_ff @(posedge clk) begin
        if (wr_en && !rollback) begin
            mem[wr_spec[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_spec   <= '0;
            wr_commit <= '0;
            rd        <= '0;
        end else begin
            if (rollback) begin
                wr_spec <= wr_commit;
            end else if (wr_en) begin
                wr_spec <= wr_spec + PW'(1);
            end
            if (commit) begin
                wr_commit <= wr_spec;
            end
            if (dout_valid && pop_ready) begin
                rd <= rd + PW'(1);
            end
        end
    end

endmodule

// File: rtl/video_line_decoder.sv
// Recovers the byte stream embedded in active video lines on the tape path.
// Each line carries a start marker, PAYLOAD_BYTES data bytes and a CRC-8;
// payload reaches the output FIFO only when the CRC matches.
//   clk, rst        : pixel clock, asynchronous active-low reset
//   hs              : active-low line sync, falling edge starts a line
//   sample_valid    : qualifies sample
//   sample          : 8-bit luma sample
//   dout, dout_valid, dout_ready : committed byte stream (valid/ready)
//   line_good       : pulse, line CRC matched and payload committed
//   line_bad        : pulse, CRC mismatch or line aborted mid-payload
//   line_dropped    : pulse, marker seen but FIFO lacks room for a line
//   level           : committed bytes waiting in the FIFO
//
// state   | meaning
// IDLE    | waiting for a line sync edge
// SKIP    | discarding the ACTIVE_START samples before the first bit
// MARKER  | receiving the start marker byte
// PAYLOAD | receiving payload bytes into the FIFO speculatively
// CHECK   | receiving the CRC byte and comparing it
// COMMIT  | publishing the line's payload
// DROP    | no room for this line, waiting for the next sync edge
module video_line_decoder
    import datatape_pkg::*;
#(
    parameter int         SPS           = 4,
    parameter int         PAYLOAD_BYTES = 32,
    parameter logic [7:0] THRESHOLD     = 8'd128,
    parameter int         ACTIVE_START  = 128,
    parameter int         FIFO_DEPTH    = 128
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          hs,
    input  logic                          sample_valid,
    input  logic [7:0]                    sample,
    output logic [7:0]                    dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic                          line_good,
    output logic                          line_bad,
    output logic                          line_dropped,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = (SPS > 1) ? $clog2(SPS) : 1;
    localparam int VW = $clog2(SPS + 1);
    localparam int KW = $clog2(ACTIVE_START + 1);
    localparam int PW = $clog2(PAYLOAD_BYTES + 1);

    state_t        state;
    logic          hs_q;
    logic          line_edge;
    logic [KW-1:0] skip_cnt;
    logic [PW-1:0] payload_cnt;
    logic [SW-1:0] sym_cnt;
    logic [VW-1:0] votes;
    logic [VW-1:0] votes_now;
    logic [2:0]    bit_cnt;
    logic [6:0]    shreg;
    logic [7:0]    crc;
    logic [7:0]    new_byte;
    logic          in_bits;
    logic          sym_end;
    logic          bit_now;
    logic          byte_done;
    logic          wr_en;
    logic          commit;
    logic          rollback;
    logic [LW-1:0] free;

    assign line_edge = hs_q & ~hs;
    assign in_bits   = (state == MARKER) || (state == PAYLOAD) || (state == CHECK);

    // Votes include the current sample so the bit decision is available on
    // the cycle the last sample of the symbol arrives.
    assign votes_now = votes + VW'(sample >= THRESHOLD);
    assign bit_now   = votes_now > VW'(SPS / 2);
    assign sym_end   = in_bits & sample_valid & ~line_edge & (sym_cnt == SW'(SPS - 1));
    assign byte_done = sym_end & (bit_cnt == 3'd7);
    assign new_byte  = {shreg, bit_now};

    assign wr_en    = (state == PAYLOAD) & byte_done;
    assign commit   = (state == COMMIT);
    assign rollback = (((state == PAYLOAD) || (state == CHECK)) & line_edge)
                    | ((state == CHECK) & byte_done & (new_byte != crc));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            hs_q         <= 1'b1;
            skip_cnt     <= '0;
            payload_cnt  <= '0;
            sym_cnt      <= '0;
            votes        <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            crc          <= '0;
            line_good    <= 1'b0;
            line_bad     <= 1'b0;
            line_dropped <= 1'b0;
        end else begin
            hs_q         <= hs;
            line_good    <= 1'b0;
            line_bad     <= 1'b0;
            line_dropped <= 1'b0;

            if (line_edge) begin
                sym_cnt  <= '0;
                votes    <= '0;
                bit_cnt  <= '0;
                shreg    <= '0;
                skip_cnt <= KW'(ACTIVE_START);
                if ((state == PAYLOAD) || (state == CHECK)) begin
                    line_bad <= 1'b1;
                end
                // The CRC already matched; the commit still happens this cycle.
                if (state == COMMIT) begin
                    line_good <= 1'b1;
                end
                state <= SKIP;
            end else begin
                if (in_bits && sample_valid) begin
                    if (sym_end) begin
                        sym_cnt <= '0;
                        votes   <= '0;
                        shreg   <= new_byte[6:0];
                        bit_cnt <= bit_cnt + 3'd1;
                    end else begin
                        sym_cnt <= sym_cnt + SW'(1);
                        votes   <= votes_now;
                    end
                end

                case (state)
                    IDLE, DROP: begin
                        state <= state;
                    end
                    SKIP: begin
                        if (sample_valid) begin
                            if (skip_cnt <= KW'(1)) begin
                                state <= MARKER;
                            end else begin
                                skip_cnt <= skip_cnt - KW'(1);
                            end
                        end
                    end
                    MARKER: begin
                        if (byte_done) begin
                            if (new_byte != START_MARKER) begin
                                state <= IDLE;
                            end else if (free >= LW'(PAYLOAD_BYTES)) begin
                                state       <= PAYLOAD;
                                crc         <= 8'h00;
                                payload_cnt <= PW'(PAYLOAD_BYTES);
                            end else begin
                                state        <= DROP;
                                line_dropped <= 1'b1;
                            end
                        end
                    end
                    PAYLOAD: begin
                        if (byte_done) begin
                            crc <= crc8_byte(crc, new_byte);
                            if (payload_cnt == PW'(1)) begin
                                state <= CHECK;
                            end else begin
                                payload_cnt <= payload_cnt - PW'(1);
                            end
                        end
                    end
                    CHECK: begin
                        if (byte_done) begin
                            if (new_byte == crc) begin
                                state <= COMMIT;
                            end else begin
                                line_bad <= 1'b1;
                                state    <= IDLE;
                            end
                        end
                    end
                    COMMIT: begin
                        line_good <= 1'b1;
                        state     <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    commit_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (new_byte),
        .commit     (commit),
        .rollback   (rollback),
        .pop_ready  (dout_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .free       (free),
        .level      (level)
    );

endmodule

// File: doc/video_line_decoder.md
Name: video_line_decoder

Overview:
- Receive-side data recovery for the tape path: takes 8-bit luma samples from the video input capture and recovers the byte stream that the video output path wrote into each active line.
- Per line: start marker, fixed-length payload, CRC-8. Payload is committed to an internal FIFO only if the CRC matches.
- Downstream (the Ethernet TX payload path) reads through a valid/ready interface.

Parameters:
- SPS, 4: samples per bit symbol.
- PAYLOAD_BYTES, 32: data bytes per line.
- THRESHOLD, 8'd128: a sample >= THRESHOLD counts as a high vote.
- ACTIVE_START, 128: valid samples skipped after the line sync edge before the first bit.
- FIFO_DEPTH, 128: FIFO entries; power of 2, >= 2*PAYLOAD_BYTES.

Ports:
- clk  in  1  pixel clock (27 MHz capture clock).
- rst  in  1  asynchronous active-low reset.
- hs  in  1  line sync, active-low; its falling edge marks line start.
- sample_valid  in  1  sample qualifier.
- sample  in  8  luma sample.
- dout  out  8  FIFO head byte.
- dout_valid  out  1  committed data available.
- dout_ready  in  1  consumer accepts dout.
- line_good  out  1  one-cycle pulse: line CRC matched and payload committed.
- line_bad  out  1  one-cycle pulse: CRC mismatch or line aborted mid-payload.
- line_dropped  out  1  one-cycle pulse: marker found but insufficient FIFO space.
- level  out  $clog2(FIFO_DEPTH)+1  committed entries.

Behaviour:
- Reset (rst low, async): state IDLE, hs_q=1, all pointers 0, dout_valid=0, level=0, all pulses 0, dout=0.
- hs edge detect: hs_q registered every clk; line edge = hs_q & ~hs.
- Symbol decision:
  - Count high votes over SPS valid samples.
  - bit = (votes > SPS/2); ties decode as 0.
  - Bits are MSB-first into a shift register; a byte completes every 8 bits.
  - Invalid samples are ignored and do not advance counters.
- FSM:
  - IDLE: on line edge -> SKIP.
  - SKIP: count ACTIVE_START valid samples -> MARKER.
  - MARKER: after 8 bits, compare with START_MARKER (0xA5).
    - Mismatch -> IDLE silently (blank/non-data line, no pulse).
    - Match with free >= PAYLOAD_BYTES -> PAYLOAD, with CRC cleared to 0x00.
    - Match with free < PAYLOAD_BYTES -> DROP, line_dropped pulse.
  - PAYLOAD: each completed byte is written at wr_spec, wr_spec++, and folded into the CRC. After PAYLOAD_BYTES bytes -> CHECK.
  - CHECK: after 8 bits, compare the received byte with the running CRC.
    - Equal -> COMMIT.
    - Not equal -> wr_spec <= wr_commit, line_bad pulse, -> IDLE.
  - COMMIT (1 cycle): wr_commit <= wr_spec, line_good pulse, -> IDLE.
  - DROP: ignore samples until the next line edge -> SKIP.
- Line edge in any state other than IDLE/DROP restarts at SKIP.
  - If the edge arrives during PAYLOAD or CHECK: rollback wr_spec <= wr_commit and pulse line_bad.
  - Bit and symbol counters clear on every line edge.
- CRC-8: polynomial 0x07, init 0x00, no reflection, no final XOR, over payload bytes only.
- FIFO:
  - First-word-fall-through.
  - dout_valid = (wr_commit != rd); dout = mem[rd].
  - Pop when dout_valid & dout_ready.
  - free = FIFO_DEPTH - (wr_spec - rd).
  - level = wr_commit - rd. Pointers are one bit wider than the address and wrap naturally.
  - Pop and commit in the same cycle are both honoured: level = old + PAYLOAD_BYTES - 1.
  - Uncommitted bytes are never visible.
- Latency: CRC byte's last sample accepted in cycle N -> COMMIT in N+1 -> dout_valid high in N+2 (FIFO previously empty).
- Pulses are mutually exclusive per cycle.

Decomposition:
- datatape_pkg contains:
  - START_MARKER = 8'hA5 and CRC8_POLY = 8'h07.
  - Function crc8_byte(crc, byte).
  - FSM state enum: IDLE, SKIP, MARKER, PAYLOAD, CHECK, COMMIT, DROP.
- One sub-module, commit_fifo, holds storage, wr_spec/wr_commit/rd pointers, commit/rollback inputs, free and level outputs.
- Symbol voting, FSM and CRC stay in video_line_decoder.

Test Plan:
- Reset: assert rst mid-line with 10 bytes written -> dout_valid=0, level=0, no pulses; first line after release decodes normally.
- Good line: marker 0xA5, 32x 0x00, CRC 0x00, dout_ready=1 -> one line_good pulse; 32 bytes 0x00 out; dout_valid rises 2 cycles after the last CRC sample.
- Bad CRC: same line with CRC byte 0x01 -> one line_bad pulse, level stays 0, dout_valid never asserts.
- Voting: bit samples {200,200,10,10} -> 0; {200,200,200,10} -> 1; {128,127,127,127} -> 0. Check via payload byte compared against the bench CRC model.
- Overflow: dout_ready=0, four good lines -> level=128. Fifth line -> line_dropped pulse, level stays 128. Release dout_ready -> 128 bytes drained in order.
- Abort: hs falls after 10 payload bytes -> line_bad pulse, level unchanged. Next full good line -> line_good, level=32.
